// File: rtl/spi_peripheral_mode3.sv
// SPI mode 3 (CPOL=1, CPHA=1) responder, MSB first, one byte per 8 SCLK cycles.
// All SPI inputs are oversampled in the clk domain. Edges are detected against
// the previous synchronized sample. The local TX side is a one-entry holding
// register with a valid/ready handshake.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no frame; SPI_MISO parked high; waiting for SPI_EN to rise
// ACTIVE | frame open; shift on SCLK edges until SPI_EN falls
module spi_peripheral_mode3 #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SPI_CLK,
  input  logic       SPI_EN,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       tx_underrun,
  output logic       frame_abort
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, en_sync, mosi_sync;
  logic                   sclk_s, en_s, mosi_s;
  logic                   sclk_prev, en_prev;
  logic                   sclk_fall, sclk_rise, en_rise, en_fall;

  logic [7:0] hold_data;
  logic       hold_valid;
  logic [7:0] tx_shift, rx_shift;
  logic [2:0] bit_cnt;

  logic       start_frame, launch, sample, end_frame, abort_frame;
  logic       load_req, hold_take, underrun;
  logic [7:0] load_val;

  // Input synchronizers. SCLK resets to its idle-high level so that leaving
  // reset does not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      en_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], SPI_EN};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign en_s   = en_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Previous synchronized samples for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b1;
      en_prev   <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      en_prev   <= en_s;
    end
  end

  // SCLK edges qualify on the current EN, so an EN fall masks a coincident edge.
  assign en_rise   =  en_s & ~en_prev;
  assign en_fall   = ~en_s &  en_prev;
  assign sclk_fall =  en_s &  sclk_prev & ~sclk_s;
  assign sclk_rise =  en_s & ~sclk_prev &  sclk_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    launch      = 1'b0;
    sample      = 1'b0;
    end_frame   = 1'b0;
    abort_frame = 1'b0;
    case (state)
      IDLE: begin
        if (en_rise) begin
          start_frame = 1'b1;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (en_fall) begin
          end_frame   = 1'b1;
          abort_frame = (bit_cnt != 3'd0);
          state_nxt   = IDLE;
        end else if (sclk_fall) begin
          launch = 1'b1;
        end else if (sclk_rise) begin
          sample = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_req  = start_frame | (sample & (bit_cnt == 3'd7));
  assign hold_take = tx_valid & tx_ready;
  assign underrun  = load_req & ~hold_valid;
  assign load_val  = hold_valid ? hold_data : IDLE_FILL;
  assign tx_ready  = ~hold_valid;
  assign busy      = (state == ACTIVE);

  // Holding register. A load that finds it empty takes IDLE_FILL, and a byte
  // captured in that same cycle waits here for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (load_req && hold_valid) begin
      hold_valid <= 1'b0;
    end else if (hold_take) begin
      hold_data  <= tx_data;
      hold_valid <= 1'b1;
    end
  end

  // Shift datapath, received byte and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      SPI_MISO    <= 1'b1;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= underrun;
      frame_abort <= abort_frame;
      if (start_frame) begin
        tx_shift <= load_val;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (launch) begin
        SPI_MISO <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (sample) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift[6:0], mosi_s};
          rx_valid <= 1'b1;
          tx_shift <= load_val;
        end
      end
      if (end_frame) SPI_MISO <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_peripheral_mode3.sv
// Directed bench for spi_peripheral_mode3: a table of single-byte frames plus
// hand-written multi-byte, abort, reset and load-collision sequences.
module tb_spi_peripheral_mode3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SPI_CLK = 1'b1;
  logic       SPI_EN = 1'b0;
  logic       SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;
  logic       frame_abort;

  int checks = 0;
  int failures = 0;
  int n_rxv = 0, n_und = 0, n_abt = 0;
  int b_rxv, b_und, b_abt;
  logic [7:0] m0, m1, m2;

  typedef struct {
    bit         pre_valid;
    logic [7:0] pre;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[4];

  spi_peripheral_mode3 #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Count one-cycle pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid)    n_rxv++;
      if (tx_underrun) n_und++;
      if (frame_abort) n_abt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_rxv = n_rxv;
    b_und = n_und;
    b_abt = n_abt;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=tx_ready_low required=tx_ready_high");
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode 3 master: launch on falling SCLK, sample MISO just before rising SCLK.
  // Bit j's rising SCLK is driven 8*j+4 negedges after the call.
  task automatic spi_bits(input logic [7:0] mosi, input int n, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      SPI_CLK  = 1'b0;
      SPI_MOSI = mosi[i];
      repeat (4) @(negedge clk);
      miso[i]  = SPI_MISO;
      SPI_CLK  = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame_start();
    SPI_EN = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    SPI_EN = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b1, 8'hE1, 8'h5A, 8'hE1, 0};

    repeat (3) @(negedge clk);
    chk("rst_miso", SPI_MISO, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_abort", frame_abort, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte frames. A filler byte written mid-byte keeps the end-of-byte
    // reload from underrunning, so only an empty holding register at EN rise
    // produces tx_underrun.
    foreach (vecs[i]) begin
      snap();
      if (vecs[i].pre_valid) begin
        push_tx(vecs[i].pre);
        chk($sformatf("vec%0d_ready_full", i), tx_ready, 0);
      end
      frame_start();
      chk($sformatf("vec%0d_busy", i), busy, 1);
      chk($sformatf("vec%0d_ready_loaded", i), tx_ready, 1);
      fork
        spi_bits(vecs[i].mosi, 8, m0);
        begin
          repeat (20) @(negedge clk);
          push_tx(8'h00);
        end
      join
      frame_end();
      chk($sformatf("vec%0d_miso", i), m0, vecs[i].exp_miso);
      chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].mosi);
      chk($sformatf("vec%0d_rx_valid_cnt", i), n_rxv - b_rxv, 1);
      chk($sformatf("vec%0d_underrun_cnt", i), n_und - b_und, vecs[i].exp_und);
      chk($sformatf("vec%0d_idle_busy", i), busy, 0);
      chk($sformatf("vec%0d_idle_miso", i), SPI_MISO, 1);
    end

    // Two-byte frame with the second TX byte written during byte one.
    snap();
    push_tx(8'h12);
    chk("two_ready_before", tx_ready, 0);
    frame_start();
    chk("two_ready_after_load", tx_ready, 1);
    fork
      spi_bits(8'hC3, 8, m0);
      begin
        repeat (20) @(negedge clk);
        push_tx(8'h34);
        chk("two_ready_after_write", tx_ready, 0);
      end
    join
    chk("two_rx_byte1", rx_data, 8'hC3);
    chk("two_ready_after_reload", tx_ready, 1);
    spi_bits(8'h5A, 8, m1);
    frame_end();
    chk("two_miso_byte1", m0, 8'h12);
    chk("two_miso_byte2", m1, 8'h34);
    chk("two_rx_byte2", rx_data, 8'h5A);
    chk("two_rx_valid_cnt", n_rxv - b_rxv, 2);
    // Reload after the final byte finds the holding register empty.
    chk("two_underrun_cnt", n_und - b_und, 1);

    // EN dropped after five sampled bits.
    snap();
    frame_start();
    spi_bits(8'hF0, 5, m0);
    frame_end();
    chk("abort_cnt", n_abt - b_abt, 1);
    chk("abort_rx_valid_cnt", n_rxv - b_rxv, 0);
    chk("abort_rx_data", rx_data, 8'h5A);
    chk("abort_miso", SPI_MISO, 1);
    chk("abort_busy", busy, 0);
    snap();
    frame_start();
    spi_bits(8'h99, 8, m0);
    frame_end();
    chk("after_abort_rx", rx_data, 8'h99);
    chk("after_abort_rx_valid_cnt", n_rxv - b_rxv, 1);
    chk("after_abort_no_abort", n_abt - b_abt, 0);

    // Reset mid-frame after three bits; MISO holds bit 5 of C6 (a 0) beforehand.
    push_tx(8'hC6);
    frame_start();
    spi_bits(8'hE7, 3, m0);
    chk("midrst_busy_before", busy, 1);
    chk("midrst_miso_before", SPI_MISO, 0);
    rst_n  = 1'b0;
    SPI_EN = 1'b0;
    #1;
    chk("midrst_miso", SPI_MISO, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_rx_valid", rx_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    push_tx(8'h3C);
    frame_start();
    fork
      spi_bits(8'hE7, 8, m0);
      begin
        repeat (20) @(negedge clk);
        push_tx(8'h00);
      end
    join
    frame_end();
    chk("postrst_rx", rx_data, 8'hE7);
    chk("postrst_miso", m0, 8'h3C);
    chk("postrst_rx_valid_cnt", n_rxv - b_rxv, 1);

    // tx_valid lands in the exact cycle of the byte-boundary reload with the
    // holding register empty: the byte after it is IDLE_FILL, then 77.
    push_tx(8'h11);
    frame_start();
    snap();
    fork
      spi_bits(8'h01, 8, m0);
      begin
        repeat (62) @(negedge clk);
        chk("coll_ready_at_boundary", tx_ready, 1);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chk("coll_underrun_boundary", n_und - b_und, 1);
    chk("coll_ready_held", tx_ready, 0);
    spi_bits(8'h02, 8, m1);
    spi_bits(8'h03, 8, m2);
    frame_end();
    chk("coll_miso_byte1", m0, 8'h11);
    chk("coll_miso_byte2", m1, 8'hFF);
    chk("coll_miso_byte3", m2, 8'h77);
    chk("coll_underrun_total", n_und - b_und, 2);
    chk("coll_rx", rx_data, 8'h03);
    chk("coll_rx_valid_cnt", n_rxv - b_rxv, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
